alu: RTL and testbench

//   32-bit integer ALU for the RV32I datapath, in the execute stage.
//   - Performs the ten RV32I register-register operations on rs1/rs2, selected by a 4-bit control code.
//   - Result and zero flag are registered: one-cycle latency, one clock domain.
//   - Zflag feeds branch resolution.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 32 +++
 rtl/alu.sv | 73 +++++++
 tb/tb_alu.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32I execute stage.
// The decoder imports these so both sides agree on operation codes.
package alu_pkg;

   localparam int XLEN = 32;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 4'd0;
   localparam alu_op_t ALU_SUB  = 4'd1;
   localparam alu_op_t ALU_AND  = 4'd2;
   localparam alu_op_t ALU_OR   = 4'd3;
   localparam alu_op_t ALU_XOR  = 4'd4;
   localparam alu_op_t ALU_SLL  = 4'd5;
   localparam alu_op_t ALU_SRL  = 4'd6;
   localparam alu_op_t ALU_SRA  = 4'd7;
   localparam alu_op_t ALU_SLT  = 4'd8;
   localparam alu_op_t ALU_SLTU = 4'd9;

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] r;
      r = '0;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = x[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter shared by SLL, SRL and SRA.
// Left shifts reuse the right-shift network by reversing bits around it.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] data,
   input  logic [4:0]      shamt,
   input  logic            dir,
   input  logic            arith,
   output logic [XLEN-1:0] result
);

   logic            fill;
   logic [XLEN-1:0] s0;
   logic [XLEN-1:0] s1;
   logic [XLEN-1:0] s2;
   logic [XLEN-1:0] s3;
   logic [XLEN-1:0] s4;
   logic [XLEN-1:0] s5;

   always_comb begin
      fill = arith & dir & data[XLEN-1];
      s0   = dir ? data : bit_rev(data);
      s1   = shamt[0] ? {fill, s0[XLEN-1:1]} : s0;
      s2   = shamt[1] ? {{2{fill}}, s1[XLEN-1:2]} : s1;
      s3   = shamt[2] ? {{4{fill}}, s2[XLEN-1:4]} : s2;
      s4   = shamt[3] ? {{8{fill}}, s3[XLEN-1:8]} : s3;
      s5   = shamt[4] ? {{16{fill}}, s4[XLEN-1:16]} : s4;
      result = dir ? s5 : bit_rev(s5);
   end

endmodule

// File: rtl/alu.sv
// RV32I register-register ALU with registered result and zero flag.
// One-cycle latency, a new operation accepted every clock.
module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  alu_op_t         ALUcontrol,
   output logic [XLEN-1:0] ALUresult,
   output logic            Zflag
);

   logic            is_sub;
   logic [XLEN-1:0] addsub;
   logic            lt_s;
   logic            lt_u;
   logic            sh_dir;
   logic            sh_arith;
   logic [XLEN-1:0] sh_res;
   logic [XLEN-1:0] result_d;
   logic            zflag_d;
   logic [XLEN-1:0] result_q;
   logic            zflag_q;

   assign is_sub   = (ALUcontrol == ALU_SUB);
   assign addsub   = rs1 + (is_sub ? ~rs2 : rs2) + {{(XLEN-1){1'b0}}, is_sub};
   assign lt_s     = $signed(rs1) < $signed(rs2);
   assign lt_u     = rs1 < rs2;
   assign sh_dir   = (ALUcontrol != ALU_SLL);
   assign sh_arith = (ALUcontrol == ALU_SRA);

   alu_shifter u_shifter (
      .data   (rs1),
      .shamt  (rs2[4:0]),
      .dir    (sh_dir),
      .arith  (sh_arith),
      .result (sh_res)
   );

   always_comb begin
      result_d = '0;
      case (ALUcontrol)
         ALU_ADD,
         ALU_SUB:  result_d = addsub;
         ALU_AND:  result_d = rs1 & rs2;
         ALU_OR:   result_d = rs1 | rs2;
         ALU_XOR:  result_d = rs1 ^ rs2;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  result_d = sh_res;
         ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, lt_u};
         default:  result_d = '0;
      endcase
      zflag_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zflag_q  <= 1'b1;
      end else begin
         result_q <= result_d;
         zflag_q  <= zflag_d;
      end
   end

   assign ALUresult = result_q;
   assign Zflag     = zflag_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expectations, monitor checks them.
// Reference model is written directly from the RV32I operation definitions.
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] r;
      logic        z;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [3:0]  ALUcontrol;
   logic [31:0] ALUresult;
   logic        Zflag;

   exp_t exp_q[$];
   int   errors;
   int   checks;

   alu dut (
      .clk        (clk),
      .rst        (rst),
      .rs1        (rs1),
      .rs2        (rs2),
      .ALUcontrol (ALUcontrol),
      .ALUresult  (ALUresult),
      .Zflag      (Zflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input int op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint unsigned ua;
      longint unsigned ub;
      longint          sa;
      longint          sb;
      int              sh;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      case (op)
         0: return 32'((ua + ub) % 64'h1_0000_0000);
         1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
         6: return 32'(ua / (64'd1 << sh));
         7: begin
            // floor division gives sign-filled right shift
            longint q;
            q = sa / (longint'(1) << sh);
            if (sa < 0 && (sa % (longint'(1) << sh)) != 0) q = q - 1;
            return 32'(q);
         end
         8: return (sa < sb) ? 32'd1 : 32'd0;
         9: return (ua < ub) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input string nm);
      exp_t e;
      @(negedge clk);
      rst        = r;
      rs1        = a;
      rs2        = b;
      ALUcontrol = 4'(op);
      if (r) begin
         e.r = 32'd0;
      end else begin
         e.r = model(op, a, b);
      end
      e.z    = (e.r == 32'd0);
      e.name = nm;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ALUresult !== e.r || Zflag !== e.z) begin
               errors++;
               $display("FAIL %s: got r=%h z=%b want r=%h z=%b",
                        e.name, ALUresult, Zflag, e.r, e.z);
            end
         end
      end
   end

   initial begin
      int op;
      logic [31:0] a;
      logic [31:0] b;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      rs1 = 32'd0;
      rs2 = 32'd0;
      ALUcontrol = 4'd0;

      issue(0, 32'h1234_5678, 32'h1, 1'b1, "reset0");
      issue(0, 32'h1234_5678, 32'h1, 1'b1, "reset1");

      for (int i = 0; i < 10; i++) begin
         issue(i, 32'd2, 32'd1, 1'b0, $sformatf("sweep%0d", i));
      end

      for (int i = 0; i < 5; i++) begin
         issue(i, 32'd2, 32'd1, 1'b0, $sformatf("pre%0d", i));
      end
      issue(5, 32'd2, 32'd1, 1'b1, "midrst");
      for (int i = 5; i < 10; i++) begin
         issue(i, 32'd2, 32'd1, 1'b0, $sformatf("post%0d", i));
      end

      issue(6, 32'h8000_0000, 32'd4, 1'b0, "srl4");
      issue(7, 32'h8000_0000, 32'd4, 1'b0, "sra4");
      issue(5, 32'h8000_0000, 32'd4, 1'b0, "sll4");
      issue(7, 32'h8000_0000, 32'h20, 1'b0, "sra_amt0");
      issue(5, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "sll31");
      issue(7, 32'h8000_0000, 32'd31, 1'b0, "sra31");
      issue(8, 32'hFFFF_FFFF, 32'd1, 1'b0, "slt_neg");
      issue(9, 32'hFFFF_FFFF, 32'd1, 1'b0, "sltu_big");
      issue(8, 32'd5, 32'd5, 1'b0, "slt_eq");
      issue(9, 32'd5, 32'd5, 1'b0, "sltu_eq");
      issue(8, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "slt_ovf");
      issue(0, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_wrap");
      issue(0, 32'h7FFF_FFFF, 32'd1, 1'b0, "add_ovf");
      issue(1, 32'd0, 32'd1, 1'b0, "sub_wrap");
      issue(1, 32'd7, 32'd7, 1'b0, "sub_zero");
      for (int i = 10; i < 16; i++) begin
         issue(i, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, $sformatf("rsv%0d", i));
      end

      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(15, 0));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(3, 0) == 0) b = a;
         if ($urandom_range(3, 0) == 0) b = b & 32'h1F;
         issue(op, a, b, ($urandom_range(40, 0) == 0), $sformatf("rnd%0d", i));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
